// File: rtl/bidir_ring_counter.sv
// Bidirectional ring / Johnson shift counter with parallel load, self-correction
// of illegal states, binary position output and a one-cycle wrap pulse.
module bidir_ring_counter #(
  parameter  int WIDTH = 4,
  localparam int POS_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [POS_W-1:0] pos,
  output logic             tc,
  output logic             err
);

  localparam logic [POS_W-1:0] RING_MAX = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] JOHN_MAX = POS_W'(2*WIDTH - 1);

  // Johnson codes are either a run of ones from bit 0 or a run of ones from
  // the MSB; both tests accept all-zeros and all-ones.
  function automatic logic legal_of(input logic [WIDTH-1:0] v, input logic m);
    logic [WIDTH-1:0] nv;
    nv = ~v;
    if (!m) legal_of = $onehot(v);
    else    legal_of = ((v & (v + 1'b1)) == '0) || ((nv & (nv + 1'b1)) == '0);
  endfunction

  function automatic logic [POS_W-1:0] pos_of(input logic [WIDTH-1:0] v, input logic m);
    logic [WIDTH-1:0] lo;
    pos_of = '0;
    lo     = '0;
    if (!m) begin
      for (int i = 0; i < WIDTH; i++)
        if (v == (WIDTH'(1) << i)) pos_of = POS_W'(i);
    end else begin
      for (int k = 0; k <= WIDTH; k++) begin
        if (v == lo) pos_of = POS_W'(k);
        if (k >= 1 && k <= WIDTH-1 && v == ~lo) pos_of = POS_W'(WIDTH + k);
        lo = {lo[WIDTH-2:0], 1'b1};
      end
    end
  endfunction

  function automatic logic [WIDTH-1:0] step_of(input logic [WIDTH-1:0] v, input logic m,
                                               input logic d);
    case ({m, d})
      2'b00:   step_of = {v[WIDTH-2:0], v[WIDTH-1]};
      2'b01:   step_of = {v[0], v[WIDTH-1:1]};
      2'b10:   step_of = {v[WIDTH-2:0], ~v[WIDTH-1]};
      default: step_of = {~v[0], v[WIDTH-1:1]};
    endcase
  endfunction

  logic [WIDTH-1:0] r_q;
  logic [POS_W-1:0] r_pos;
  logic             r_tc;
  logic             r_err;

  logic             w_cur_legal;
  logic [POS_W-1:0] w_cur_pos;
  logic [POS_W-1:0] w_max;
  logic [WIDTH-1:0] w_rst_q;
  logic [WIDTH-1:0] w_nxt_q;
  logic [POS_W-1:0] w_nxt_pos;
  logic [POS_W-1:0] w_ld_pos;
  logic             w_wrap;

  always_comb begin
    w_cur_legal = legal_of(r_q, mode);
    w_cur_pos   = pos_of(r_q, mode);
    w_max       = mode ? JOHN_MAX : RING_MAX;
    w_rst_q     = mode ? '0 : WIDTH'(1);
    w_nxt_q     = step_of(r_q, mode, dir);
    w_nxt_pos   = pos_of(w_nxt_q, mode);
    w_ld_pos    = pos_of(load_val, mode);
    // Wrap is judged on the pre-step position so it matches the direction.
    w_wrap      = dir ? (w_cur_pos == '0) : (w_cur_pos == w_max);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= w_rst_q;
      r_pos <= '0;
      r_tc  <= 1'b0;
      r_err <= 1'b0;
    end else if (load) begin
      r_q   <= load_val;
      r_pos <= w_ld_pos;
      r_tc  <= 1'b0;
      r_err <= 1'b0;
    end else if (!w_cur_legal) begin
      r_q   <= w_rst_q;
      r_pos <= '0;
      r_tc  <= 1'b0;
      r_err <= 1'b1;
    end else if (en) begin
      r_q   <= w_nxt_q;
      r_pos <= w_nxt_pos;
      r_tc  <= w_wrap;
      r_err <= 1'b0;
    end else begin
      r_pos <= w_cur_pos;
      r_tc  <= 1'b0;
      r_err <= 1'b0;
    end
  end

  assign q   = r_q;
  assign pos = r_pos;
  assign tc  = r_tc;
  assign err = r_err;

endmodule

// File: tb/tb_bidir_ring_counter.sv
// Bench for bidir_ring_counter: directed walk-through followed by random
// traffic, checked against a position-arithmetic model of the counter.
module tb_bidir_ring_counter;

  localparam int W  = 4;
  localparam int PW = $clog2(2*W);

  logic          clk = 1'b0;
  logic          rst, en, dir, mode, load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q;
  logic [PW-1:0] pos;
  logic          tc, err;

  int n_tests = 0;
  int n_fail  = 0;

  int mq, mp;
  bit mtc, merr;

  bidir_ring_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(load_val), .q(q), .pos(pos), .tc(tc), .err(err)
  );

  always #5 clk = ~clk;

  // Code word sitting at step p of the sequence for mode m.
  function automatic int code_of(input bit m, input int p);
    if (!m)        return 1 << p;
    else if (p <= W) return (1 << p) - 1;
    else           return ((1 << W) - 1) & ~((1 << (p - W)) - 1);
  endfunction

  function automatic int len_of(input bit m);
    return m ? 2*W : W;
  endfunction

  // Step index of v in mode m, or -1 when v is not a code of that mode.
  function automatic int find(input bit m, input int v);
    for (int p = 0; p < len_of(m); p++)
      if (code_of(m, p) == v) return p;
    return -1;
  endfunction

  task automatic model(input bit r, input bit ld, input int lv, input bit e,
                       input bit d, input bit m);
    int idx, n;
    n   = len_of(m);
    idx = find(m, mq);
    if (r) begin
      mq = m ? 0 : 1; mp = 0; mtc = 0; merr = 0;
    end else if (ld) begin
      mq = lv; mp = (find(m, lv) < 0) ? 0 : find(m, lv); mtc = 0; merr = 0;
    end else if (idx < 0) begin
      mq = m ? 0 : 1; mp = 0; mtc = 0; merr = 1;
    end else if (e) begin
      mp   = d ? (idx + n - 1) % n : (idx + 1) % n;
      mq   = code_of(m, mp);
      mtc  = d ? (idx == 0) : (idx == n - 1);
      merr = 0;
    end else begin
      mp = idx; mtc = 0; merr = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit ld, input logic [W-1:0] lv, input bit e,
                     input bit d, input bit m);
    rst = r; load = ld; load_val = lv; en = e; dir = d; mode = m;
    model(r, ld, int'(lv), e, d, m);
    @(posedge clk); #1;
    chk("q", 32'(q), 32'(mq));
    chk("pos", 32'(pos), 32'(mp));
    chk("tc", 32'(tc), 32'(mtc));
    chk("err", 32'(err), 32'(merr));
  endtask

  initial begin
    bit r, ld, e, d, m;
    logic [W-1:0] lv;
    mq = 0; mp = 0; mtc = 0; merr = 0;
    rst = 0; load = 0; load_val = '0; en = 0; dir = 0; mode = 0;
    @(negedge clk);

    // Ring up: one full lap, wrap on the fourth step.
    cyc(1, 0, '0, 0, 0, 0);
    chk("rst_ring_q", 32'(q), 32'h1);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, 0, 0);
    chk("ring_up_wrap_q", 32'(q), 32'h1);
    chk("ring_up_wrap_tc", 32'(tc), 32'h1);

    // Ring down, then hold.
    cyc(0, 0, '0, 1, 1, 0);
    chk("ring_dn_q", 32'(q), 32'h8);
    chk("ring_dn_tc", 32'(tc), 32'h1);
    cyc(0, 0, '0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 1, 0);
    chk("ring_hold_q", 32'(q), 32'h4);

    // Johnson up for a full lap, then one step down.
    cyc(1, 0, '0, 0, 0, 1);
    chk("rst_john_q", 32'(q), 32'h0);
    for (int i = 0; i < 8; i++) cyc(0, 0, '0, 1, 0, 1);
    chk("john_up_wrap_tc", 32'(tc), 32'h1);
    cyc(0, 0, '0, 1, 1, 1);
    chk("john_dn_q", 32'(q), 32'h8);
    chk("john_dn_pos", 32'(pos), 32'h7);

    // Illegal load held one cycle then corrected.
    cyc(0, 1, 4'b0110, 0, 0, 0);
    chk("ill_load_q", 32'(q), 32'h6);
    cyc(0, 0, '0, 0, 0, 0);
    chk("ill_fix_err", 32'(err), 32'h1);

    // Mode switches.
    cyc(0, 1, 4'b0100, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 1);
    chk("r2j_q", 32'(q), 32'h0);
    cyc(0, 1, 4'b0011, 0, 0, 1);
    cyc(0, 0, '0, 0, 0, 0);
    chk("j2r_q", 32'(q), 32'h1);
    cyc(0, 1, 4'b0001, 0, 0, 1);
    chk("j_pos1", 32'(pos), 32'h1);
    cyc(0, 0, '0, 0, 0, 0);
    chk("j2r_keep_pos", 32'(pos), 32'h0);

    // Priority.
    cyc(1, 1, 4'b1000, 1, 0, 0);
    chk("prio_rst_q", 32'(q), 32'h1);
    cyc(0, 1, 4'b1000, 1, 0, 0);
    chk("prio_load_q", 32'(q), 32'h8);
    chk("prio_load_pos", 32'(pos), 32'h3);

    // Random traffic.
    m = 0;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      ld = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 9) < 7);
      d  = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) m = ~m;
      if ($urandom_range(0, 1) == 1) lv = W'(code_of(m, $urandom_range(0, len_of(m) - 1)));
      else                           lv = W'($urandom);
      cyc(r, ld, lv, e, d, m);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
